// File: rtl/shadow_register_restore.sv
// Shadow register file restore engine: walks the saved stack frame upward from
// register 0, issues pipelined cache loads and writes each returned word back.
module shadow_register_restore #(
  parameter int NUM_SHADOW_SAVES = 16,
  parameter int ADDR_WIDTH       = 6,
  parameter int DATA_WIDTH       = 32,
  parameter int PLEN             = 34,
  parameter int MAX_OUTSTANDING  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    restore_i,
  input  logic [DATA_WIDTH-1:0]   stack_ptr_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic                    req_o,
  output logic [PLEN-1:0]         addr_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  input  logic                    gnt_i,
  input  logic                    rvalid_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  input  logic                    rerr_i,
  output logic                    shadow_we_o,
  output logic [ADDR_WIDTH-1:0]   shadow_waddr_o,
  output logic [DATA_WIDTH-1:0]   shadow_wdata_o
);

  localparam int W     = DATA_WIDTH / 8;
  localparam int LOG2W = $clog2(W);
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [PLEN-1:0] STEP        = PLEN'(W);
  localparam logic [PLEN-1:0] FRAME_BYTES = PLEN'(W * NUM_SHADOW_SAVES);
  localparam logic [CW-1:0]   NUM_C       = CW'(NUM_SHADOW_SAVES);
  localparam logic [CW-1:0]   LAST_C      = CW'(NUM_SHADOW_SAVES - 1);
  localparam logic [CW-1:0]   ONE_C       = CW'(1);
  localparam logic [2:0]      MAX_C       = 3'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   issue_q, issue_d;
  logic [CW-1:0]   resp_q, resp_d;
  logic [2:0]      out_q, out_d;
  logic [PLEN-1:0] addr_q, addr_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic [PLEN-1:0] base;
  logic            aligned;
  logic            gnt_acc;
  logic            rsp_acc;

  assign base    = PLEN'(stack_ptr_i);
  assign aligned = (stack_ptr_i[LOG2W-1:0] == '0);
  // A response with nothing outstanding is stale (e.g. from before a reset).
  assign rsp_acc = rvalid_i && (out_q != 3'd0);

  always_comb begin
    state_d     = state_q;
    issue_d     = issue_q;
    resp_d      = resp_q;
    out_d       = out_q;
    addr_d      = addr_q;
    err_d       = err_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    req_o       = 1'b0;
    gnt_acc     = 1'b0;
    shadow_we_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (restore_i) begin
          if (aligned) begin
            state_d = S_LOAD;
            issue_d = '0;
            resp_d  = '0;
            out_d   = 3'd0;
            addr_d  = base - FRAME_BYTES;
            err_d   = 1'b0;
          end else begin
            done_d  = 1'b1;
            error_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        // A response in this cycle frees a slot, so issue may proceed at the limit.
        req_o   = (issue_q < NUM_C) && ((out_q < MAX_C) || rvalid_i) && !err_q;
        gnt_acc = req_o && gnt_i;
        if (gnt_acc) begin
          issue_d = issue_q + ONE_C;
          addr_d  = addr_q + STEP;
        end
        out_d = out_q + {2'b00, gnt_acc} - {2'b00, rsp_acc};
        if (rsp_acc) begin
          resp_d = resp_q + ONE_C;
          if (rerr_i) begin
            err_d = 1'b1;
            if (resp_q == LAST_C) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              error_d = 1'b1;
            end else begin
              state_d = S_DRAIN;
            end
          end else begin
            shadow_we_o = 1'b1;
            if (resp_q == LAST_C) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end

      S_DRAIN: begin
        out_d = out_q - {2'b00, rsp_acc};
        if (out_q == {2'b00, rsp_acc}) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          error_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      issue_q <= '0;
      resp_q  <= '0;
      out_q   <= 3'd0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      resp_q  <= resp_d;
      out_q   <= out_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign ready_o        = (state_q == S_IDLE);
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign addr_o         = addr_q;
  assign be_o           = {W{req_o}};
  assign shadow_waddr_o = shadow_we_o ? resp_q[ADDR_WIDTH-1:0] : '0;
  assign shadow_wdata_o = shadow_we_o ? rdata_i : '0;

  // Responses while idle are leftovers from an aborted restore and are legal.
  assert property (@(posedge clk_i) disable iff (rst_i)
    (rvalid_i && (state_q != S_IDLE)) |-> (out_q != 3'd0));
  assert property (@(posedge clk_i) disable iff (rst_i)
    restore_i |-> ready_o);

endmodule
